// File: rtl/axis_deci_fifo.sv
// rtl/axis_deci_fifo.sv - decimating capture of strobed FIR samples into a fall-through AXI-Stream FIFO
module axis_deci_fifo #(
    parameter int DATA_WIDTH   = 32,
    parameter int DECI_W       = 16,
    parameter int FIFO_DEPTH_L = 4
) (
    input  logic                    a_clk,
    input  logic                    a_resetn,
    input  logic                    next_dv,
    input  logic [DATA_WIDTH-1:0]   S_AXIS_tdata,
    input  logic                    S_AXIS_tvalid,
    input  logic [DECI_W-1:0]       deci,
    output logic [DATA_WIDTH-1:0]   M_AXIS_tdata,
    output logic                    M_AXIS_tvalid,
    input  logic                    M_AXIS_tready,
    output logic [FIFO_DEPTH_L:0]   fill_level,
    output logic                    overflow,
    input  logic                    clear_overflow
);
    localparam int DEPTH = 1 << FIFO_DEPTH_L;
    localparam logic [FIFO_DEPTH_L:0] FULL_CNT = DEPTH[FIFO_DEPTH_L:0];

    logic                    sync1_q, sync2_q, prev_q;
    logic                    live_q, armed_q, armed_d;
    logic [DECI_W-1:0]       cnt_q, cnt_d, deci_m1;
    logic [FIFO_DEPTH_L-1:0] wr_q, rd_q;
    logic [FIFO_DEPTH_L:0]   count_q, count_d;
    logic                    ovf_q, ovf_d;
    logic [DATA_WIDTH-1:0]   mem_q [DEPTH];
    logic                    event_w, hit_w, push_w, pop_w, full_w, wr_en_w;

    // A strobe already high at reset release must be seen low once before any edge counts.
    assign armed_d = armed_q | (live_q & ~sync1_q);
    assign event_w = sync2_q & ~prev_q & armed_q;

    assign deci_m1 = (deci == '0) ? '0 : deci - 1'b1;
    assign hit_w   = (cnt_q >= deci_m1);
    assign push_w  = event_w & S_AXIS_tvalid & hit_w;

    assign M_AXIS_tvalid = (count_q != '0);
    assign M_AXIS_tdata  = M_AXIS_tvalid ? mem_q[rd_q] : '0;
    assign fill_level    = count_q;
    assign overflow      = ovf_q;

    assign full_w  = (count_q == FULL_CNT);
    assign pop_w   = M_AXIS_tvalid & M_AXIS_tready;
    assign wr_en_w = push_w & (~full_w | pop_w);

    always_comb begin
        cnt_d = cnt_q;
        if (event_w) begin
            if (!S_AXIS_tvalid || hit_w) begin
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        count_d = count_q;
        case ({wr_en_w, pop_w})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // A drop in the same cycle as a clear wins, so no overflow is ever lost.
    assign ovf_d = (ovf_q & ~clear_overflow) | (push_w & full_w & ~pop_w);

    always_ff @(posedge a_clk or negedge a_resetn) begin
        if (!a_resetn) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
            live_q  <= 1'b0;
            armed_q <= 1'b0;
            cnt_q   <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            sync1_q <= next_dv;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            live_q  <= 1'b1;
            armed_q <= armed_d;
            cnt_q   <= cnt_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            if (wr_en_w) begin
                wr_q <= wr_q + 1'b1;
            end
            if (pop_w) begin
                rd_q <= rd_q + 1'b1;
            end
        end
    end

    always_ff @(posedge a_clk) begin
        if (wr_en_w) begin
            mem_q[wr_q] <= S_AXIS_tdata;
        end
    end
endmodule

// File: tb/tb_axis_deci_fifo.sv
// tb/tb_axis_deci_fifo.sv - self-checking bench for axis_deci_fifo
module tb_axis_deci_fifo;
    logic        a_clk = 1'b0;
    logic        a_resetn;
    logic        next_dv;
    logic [31:0] S_AXIS_tdata;
    logic        S_AXIS_tvalid;
    logic [15:0] deci;
    logic [31:0] M_AXIS_tdata;
    logic        M_AXIS_tvalid;
    logic        M_AXIS_tready;
    logic [4:0]  fill_level;
    logic        overflow;
    logic        clear_overflow;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] q[$];
    logic        exp_ovf = 1'b0;
    int          exp_fill;

    typedef struct {
        logic [15:0] deci;
        logic        valid;
        logic [31:0] data;
        logic        push;
    } vec_t;
    vec_t vecs[$];

    axis_deci_fifo dut (
        .a_clk          (a_clk),
        .a_resetn       (a_resetn),
        .next_dv        (next_dv),
        .S_AXIS_tdata   (S_AXIS_tdata),
        .S_AXIS_tvalid  (S_AXIS_tvalid),
        .deci           (deci),
        .M_AXIS_tdata   (M_AXIS_tdata),
        .M_AXIS_tvalid  (M_AXIS_tvalid),
        .M_AXIS_tready  (M_AXIS_tready),
        .fill_level     (fill_level),
        .overflow       (overflow),
        .clear_overflow (clear_overflow)
    );

    always #5 a_clk = ~a_clk;

    task automatic tick();
        @(posedge a_clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, got, exp);
        end
    endtask

    function automatic void add_row(input logic [15:0] d, input logic v, input logic [31:0] x, input logic p);
        vec_t r;
        r.deci = d; r.valid = v; r.data = x; r.push = p;
        vecs.push_back(r);
    endfunction

    always @(negedge a_clk) begin
        if (a_resetn && M_AXIS_tvalid && M_AXIS_tready) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_output got %0d expected none", M_AXIS_tdata);
            end else begin
                logic [31:0] e;
                e = q.pop_front();
                if (M_AXIS_tdata !== e) begin
                    errors++;
                    $display("FAIL output_order got %0d expected %0d", M_AXIS_tdata, e);
                end
            end
        end
    end

    task automatic pulse(input logic [31:0] d, input logic v, input logic exp_push,
                         input logic chk_lat, input logic cap_rdy, input logic cap_clr);
        S_AXIS_tdata  = d;
        S_AXIS_tvalid = v;
        next_dv       = 1'b1;
        tick();
        tick();
        if (chk_lat) check("pre_capture_tvalid", 32'(M_AXIS_tvalid), 0);
        if (cap_rdy) M_AXIS_tready = 1'b1;
        if (cap_clr) clear_overflow = 1'b1;
        tick();
        if (cap_rdy) M_AXIS_tready = 1'b0;
        clear_overflow = 1'b0;
        if (cap_clr) exp_ovf = 1'b0;
        if (exp_push) begin
            if (q.size() >= 16) exp_ovf = 1'b1;
            else q.push_back(d);
        end
        if (chk_lat) begin
            check("latency_tvalid", 32'(M_AXIS_tvalid), 1);
            check("latency_tdata", M_AXIS_tdata, d);
        end
        next_dv = 1'b0;
        tick();
        tick();
        tick();
    endtask

    task automatic drain();
        int n;
        n = 0;
        M_AXIS_tready = 1'b1;
        while (M_AXIS_tvalid && n < 64) begin
            tick();
            n++;
        end
        check("drain_tvalid", 32'(M_AXIS_tvalid), 0);
        M_AXIS_tready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 12; i++) add_row(16'd4, 1'b1, 32'(10 + i), (i % 4) == 3);
        for (int i = 0; i < 5; i++)  add_row(16'd8, 1'b1, 32'(30 + i), 1'b0);
        add_row(16'd8, 1'b0, 32'd35, 1'b0);
        for (int i = 0; i < 7; i++)  add_row(16'd8, 1'b1, 32'(36 + i), 1'b0);
        add_row(16'd8, 1'b1, 32'd43, 1'b1);
        add_row(16'd0, 1'b1, 32'd50, 1'b1);
        for (int i = 0; i < 3; i++)  add_row(16'd8, 1'b1, 32'(60 + i), 1'b0);
        add_row(16'd2, 1'b1, 32'd63, 1'b1);

        a_resetn = 1'b0; next_dv = 1'b0; S_AXIS_tdata = '0; S_AXIS_tvalid = 1'b0;
        deci = 16'd1; M_AXIS_tready = 1'b0; clear_overflow = 1'b0;
        tick();
        tick();
        check("reset_tvalid", 32'(M_AXIS_tvalid), 0);
        check("reset_tdata", M_AXIS_tdata, 0);
        check("reset_fill", 32'(fill_level), 0);
        check("reset_overflow", 32'(overflow), 0);

        // Strobe held high across release must not produce an event.
        next_dv = 1'b1; S_AXIS_tvalid = 1'b1; S_AXIS_tdata = 32'd999;
        tick();
        tick();
        a_resetn = 1'b1;
        repeat (6) tick();
        check("dv_high_at_release", 32'(fill_level), 0);
        next_dv = 1'b0;
        repeat (3) tick();

        M_AXIS_tready = 1'b1;
        for (int i = 1; i <= 5; i++) pulse(32'(i), 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        M_AXIS_tready = 1'b0;
        check("deci1_all_out", 32'(q.size()), 0);

        exp_fill = 0;
        foreach (vecs[i]) begin
            deci = vecs[i].deci;
            pulse(vecs[i].data, vecs[i].valid, vecs[i].push, 1'b0, 1'b0, 1'b0);
            if (vecs[i].push) exp_fill++;
            check("tbl_fill", 32'(fill_level), 32'(exp_fill));
        end
        drain();
        check("tbl_drained", 32'(q.size()), 0);

        deci = 16'd1;
        for (int i = 0; i < 16; i++) pulse(32'(100 + i), 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        check("full_fill", 32'(fill_level), 16);
        check("full_no_ovf", 32'(overflow), 0);
        pulse(32'd116, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        check("full_pushpop_fill", 32'(fill_level), 16);
        check("full_pushpop_ovf", 32'(overflow), 32'(exp_ovf));
        pulse(32'd117, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        pulse(32'd118, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        check("ovf_fill", 32'(fill_level), 16);
        check("ovf_set", 32'(overflow), 1);
        pulse(32'd119, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        check("ovf_clear_collide", 32'(overflow), 32'(exp_ovf));
        drain();
        check("ovf_drained", 32'(q.size()), 0);
        check("ovf_sticky", 32'(overflow), 1);
        clear_overflow = 1'b1;
        tick();
        clear_overflow = 1'b0;
        exp_ovf = 1'b0;
        check("ovf_cleared", 32'(overflow), 32'(exp_ovf));

        for (int i = 0; i < 7; i++) pulse(32'(150 + i), 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        check("pre_reset_fill", 32'(fill_level), 7);
        #3 a_resetn = 1'b0;
        #2;
        check("midreset_tvalid", 32'(M_AXIS_tvalid), 0);
        check("midreset_fill", 32'(fill_level), 0);
        q.delete();
        tick();
        a_resetn = 1'b1;
        repeat (3) tick();
        M_AXIS_tready = 1'b1;
        pulse(32'd200, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        repeat (3) tick();
        check("post_reset_out", 32'(q.size()), 0);
        check("post_reset_fill", 32'(fill_level), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
